// File: rtl/dlx_pipe_pkg.sv
// rtl/dlx_pipe_pkg.sv - shared types and constants for the DLX pipeline controller
package dlx_pipe_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  // Per-stage register controls; en loads the register, flush makes it load a bubble
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } stage_ctrl_t;

  // Everything frozen (reset, HALTED)
  localparam stage_ctrl_t CTRL_NONE    = 9'b00000_0000;
  // Normal advance
  localparam stage_ctrl_t CTRL_RUN     = 9'b11111_0000;
  // Data memory busy: hold front of pipe, retire a bubble into WB
  localparam stage_ctrl_t CTRL_MEMSTALL = 9'b00001_0001;
  // Taken branch: squash the two wrong-path instructions behind EX
  localparam stage_ctrl_t CTRL_BRANCH  = 9'b11111_1100;
  // Load-use: hold PC and IF/ID, insert a bubble into EX
  localparam stage_ctrl_t CTRL_LOADUSE = 9'b00111_0100;
  // Drain: stop fetching, feed bubbles in behind the last instruction
  localparam stage_ctrl_t CTRL_DRAIN   = 9'b01111_1000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stick at all-ones rather than wrapping
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dlx_pipe_ctrl.sv
// rtl/dlx_pipe_ctrl.sv - hazard and sequencing controller for the 5-stage DLX pipeline
import dlx_pipe_pkg::*;

module dlx_pipe_ctrl #(
  parameter int MEM_TIMEOUT  = 64,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  memwb_flush,
  output logic                  halted,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  state_t             state, state_n;
  logic [WAIT_W-1:0]  wait_cnt, wait_n;
  logic [DRAIN_W-1:0] drain_cnt, drain_n;
  logic               err_set;
  logic               stall_inc, flush_inc;
  logic               memstall, loaduse;
  stage_ctrl_t        ctrl;

  assign memstall = mem_req & ~mem_ready;
  // r0 is hardwired zero, so a load targeting it can never feed a dependent
  assign loaduse  = ex_is_load && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Mealy stage controls and next-state selection from state plus live hazards
  always_comb begin
    ctrl      = CTRL_NONE;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    state_n   = state;
    wait_n    = wait_cnt;
    drain_n   = drain_cnt;
    err_set   = 1'b0;
    unique case (state)
      ST_RUN, ST_MEM_WAIT: begin
        if ((state == ST_RUN && memstall) || (state == ST_MEM_WAIT && !mem_ready)) begin
          ctrl      = CTRL_MEMSTALL;
          stall_inc = 1'b1;
          // wait_cnt holds the number of stall cycles already spent in this access
          if (state == ST_MEM_WAIT && wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            err_set = 1'b1;
            state_n = ST_HALTED;
          end else begin
            wait_n  = wait_cnt + 1'b1;
            state_n = ST_MEM_WAIT;
          end
        end else begin
          wait_n = '0;
          // A branch squashes the dependent instruction anyway, so it outranks load-use
          if (ex_branch_taken) begin
            ctrl      = CTRL_BRANCH;
            flush_inc = 1'b1;
          end else if (loaduse) begin
            ctrl      = CTRL_LOADUSE;
            stall_inc = 1'b1;
          end else begin
            ctrl = CTRL_RUN;
          end
          if (halt_req) begin
            state_n = ST_DRAIN;
            drain_n = '0;
          end else begin
            state_n = ST_RUN;
          end
        end
      end
      ST_DRAIN: begin
        if (memstall) begin
          ctrl      = CTRL_MEMSTALL;
          stall_inc = 1'b1;
        end else begin
          ctrl = CTRL_DRAIN;
          if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
            state_n = ST_HALTED;
          end else begin
            drain_n = drain_cnt + 1'b1;
          end
        end
      end
      ST_HALTED: begin
        if (resume && !mem_err) begin
          state_n = ST_RUN;
        end
      end
    endcase
    if (!rst) begin
      ctrl      = CTRL_NONE;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
    end
  end

  // FSM state, wait/drain counters and the sticky timeout flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      drain_cnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_n;
      drain_cnt <= drain_n;
      if (err_set) begin
        mem_err <= 1'b1;
      end
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign idex_en     = ctrl.idex_en;
  assign exmem_en    = ctrl.exmem_en;
  assign memwb_en    = ctrl.memwb_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_flush = ctrl.memwb_flush;
  assign halted      = rst && (state == ST_HALTED);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (~rst),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (~rst),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_dlx_pipe_ctrl.sv
// tb/tb_dlx_pipe_ctrl.sv - scoreboard bench for dlx_pipe_ctrl
module tb_dlx_pipe_ctrl;

  // bit order: pc, ifid, idex, exmem, memwb, ifid_f, idex_f, exmem_f, memwb_f
  localparam logic [8:0] E_ZERO = 9'b00000_0000;
  localparam logic [8:0] E_RUN  = 9'b11111_0000;
  localparam logic [8:0] E_LU   = 9'b00111_0100;
  localparam logic [8:0] E_BR   = 9'b11111_1100;
  localparam logic [8:0] E_MS   = 9'b00001_0001;
  localparam logic [8:0] E_DR   = 9'b01111_1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_is_load, ex_branch_taken;
  logic       mem_req, mem_ready, halt_req, resume;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic       halted, mem_err;
  logic [3:0] stall_count, flush_count;
  logic [8:0] act_ctrl;

  typedef struct packed {
    logic [8:0] ctrl;
    logic       h;
    logic       e;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  exp_t  eq[$];
  string nq[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  dlx_pipe_ctrl #(.MEM_TIMEOUT(8), .DRAIN_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .halted(halted), .mem_err(mem_err), .stall_count(stall_count), .flush_count(flush_count)
  );

  assign act_ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                     ifid_flush, idex_flush, exmem_flush, memwb_flush};

  task automatic idle();
    rst = 1'b1;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  // Queue the expected response for the cycle whose inputs are now applied, then advance
  task automatic chk(input logic [8:0] c, input logic h, input logic e,
                     input int sc, input int fc, input string n);
    exp_t x;
    x.ctrl = c; x.h = h; x.e = e; x.sc = 4'(sc); x.fc = 4'(fc);
    eq.push_back(x);
    nq.push_back(n);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented output cycle against the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (eq.size() != 0) begin
        exp_t  x;
        string n;
        x = eq.pop_front();
        n = nq.pop_front();
        checks++;
        if (act_ctrl !== x.ctrl) begin
          errors++; $display("FAIL %s ctrl got %b exp %b", n, act_ctrl, x.ctrl);
        end
        checks++;
        if (halted !== x.h) begin
          errors++; $display("FAIL %s halted got %b exp %b", n, halted, x.h);
        end
        checks++;
        if (mem_err !== x.e) begin
          errors++; $display("FAIL %s mem_err got %b exp %b", n, mem_err, x.e);
        end
        checks++;
        if (stall_count !== x.sc) begin
          errors++; $display("FAIL %s stall_count got %0d exp %0d", n, stall_count, x.sc);
        end
        checks++;
        if (flush_count !== x.fc) begin
          errors++; $display("FAIL %s flush_count got %0d exp %0d", n, flush_count, x.fc);
        end
      end
    end
  end

  initial begin
    // Reset with every input asserted
    idle();
    rst = 1'b0; mem_req = 1'b1; ex_branch_taken = 1'b1; halt_req = 1'b1; resume = 1'b1;
    ex_is_load = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) chk(E_ZERO, 0, 0, 0, 0, "reset");
    idle();
    chk(E_RUN, 0, 0, 0, 0, "post_reset");

    // Load-use on rs2, then on rs1; r0 and unused operands never stall
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    chk(E_LU, 0, 0, 0, 0, "lu_rs2");
    idle();
    chk(E_RUN, 0, 0, 1, 0, "after_lu");
    ex_is_load = 1'b1; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    chk(E_RUN, 0, 0, 1, 0, "lu_rd0");
    ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd1;
    chk(E_LU, 0, 0, 1, 0, "lu_rs1");
    id_uses_rs1 = 1'b0;
    chk(E_RUN, 0, 0, 2, 0, "lu_unused");

    // Branch together with a load-use match counts as a flush only
    idle();
    ex_branch_taken = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
    chk(E_BR, 0, 0, 2, 0, "br_lu");
    idle();
    chk(E_RUN, 0, 0, 2, 1, "after_br");

    // Five wait-state cycles, then ready returns to RUN
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) chk(E_MS, 0, 0, 2 + i, 1, "mem_wait");
    mem_ready = 1'b1;
    chk(E_RUN, 0, 0, 7, 1, "mw_ready");
    idle();
    chk(E_RUN, 0, 0, 7, 1, "mw_back");

    // Halt: drain with a two-cycle memstall in the middle and an ignored branch
    halt_req = 1'b1;
    chk(E_RUN, 0, 0, 7, 1, "halt_req");
    idle();
    chk(E_DR, 0, 0, 7, 1, "drain0");
    chk(E_DR, 0, 0, 7, 1, "drain1");
    mem_req = 1'b1;
    chk(E_MS, 0, 0, 7, 1, "drain_ms0");
    chk(E_MS, 0, 0, 8, 1, "drain_ms1");
    idle();
    ex_branch_taken = 1'b1;
    chk(E_DR, 0, 0, 9, 1, "drain2_br");
    idle();
    chk(E_DR, 0, 0, 9, 1, "drain3");
    chk(E_ZERO, 1, 0, 9, 1, "halted");
    mem_req = 1'b1; ex_branch_taken = 1'b1; halt_req = 1'b1;
    chk(E_ZERO, 1, 0, 9, 1, "halted_busy");
    idle();
    resume = 1'b1;
    chk(E_ZERO, 1, 0, 9, 1, "resume");
    idle();
    chk(E_RUN, 0, 0, 9, 1, "resumed");

    // Timeout: 8 stall cycles, stall_count saturates at 15, then sticky error
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) chk(E_MS, 0, 0, (9 + i > 15) ? 15 : 9 + i, 1, "timeout");
    idle();
    resume = 1'b1;
    chk(E_ZERO, 1, 1, 15, 1, "err_resume");
    idle();
    chk(E_ZERO, 1, 1, 15, 1, "err_hold");
    rst = 1'b0;
    chk(E_ZERO, 0, 1, 15, 1, "err_reset");
    idle();
    chk(E_RUN, 0, 0, 0, 0, "after_err_reset");

    @(negedge clk);
    #1;
    checks++;
    if (eq.size() != 0) begin
      errors++;
      $display("FAIL drain_queue got %0d exp 0", eq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
